// File: rtl/tpu_wb_array.sv
// Wishbone-mapped signed vector x matrix accelerator over an N x N weight tile.
// Input vectors and results are buffered in FIFOs; a four-state FSM sequences pop, MAC and push.
module tpu_wb_array #(
    parameter int unsigned N            = 3,
    parameter int unsigned DW           = 8,
    parameter int unsigned ACCW         = 2 * DW + $clog2(N),
    parameter int unsigned IDEPTH       = 8,
    parameter int unsigned RDEPTH       = 16,
    parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
    output logic        irq_o
);
    localparam int unsigned VW  = N * DW;
    localparam int unsigned PW  = 2 * DW;
    localparam int unsigned KW  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned IAW = $clog2(IDEPTH);
    localparam int unsigned ICW = IAW + 1;
    localparam int unsigned RAW = $clog2(RDEPTH);
    localparam int unsigned RCW = RAW + 1;

    localparam logic [4:0] OFF_CTRL   = 5'h00;
    localparam logic [4:0] OFF_STATUS = 5'h04;
    localparam logic [4:0] OFF_WEIGHT = 5'h08;
    localparam logic [4:0] OFF_INPUT  = 5'h0C;
    localparam logic [4:0] OFF_RESULT = 5'h10;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_MAC, S_PUSH} state_t;

    state_t                 state_q, state_d;
    logic [KW-1:0]          k_q, k_d;
    logic [7:0]             nvec_q, nvec_d;
    logic [7:0]             vec_cnt_q, vec_cnt_d;
    logic                   done_q, done_d;
    logic                   irq_en_q, irq_en_d;
    logic                   in_ovf_q, in_ovf_d;
    logic                   res_udf_q, res_udf_d;
    logic                   w_err_q, w_err_d;
    logic [KW-1:0]          wrow_q, wrow_d;
    logic [KW-1:0]          wcol_q, wcol_d;
    logic signed [DW-1:0]   w_q [N][N];
    logic signed [DW-1:0]   w_d [N][N];
    logic signed [DW-1:0]   x_q [N];
    logic signed [DW-1:0]   x_d [N];
    logic signed [ACCW-1:0] acc_q [N];
    logic signed [ACCW-1:0] acc_d [N];
    logic signed [PW-1:0]   prod [N];

    logic [VW-1:0]          in_mem_q [IDEPTH];
    logic [IAW-1:0]         in_wr_q, in_wr_d, in_rd_q, in_rd_d;
    logic [ICW-1:0]         in_cnt_q, in_cnt_d;
    logic signed [ACCW-1:0] res_mem_q [RDEPTH];
    logic [RAW-1:0]         res_wr_q, res_wr_d, res_rd_q, res_rd_d;
    logic [RCW-1:0]         res_cnt_q, res_cnt_d;

    logic                   ack_q, ack_d;
    logic [31:0]            dat_q, dat_d;
    logic                   irq_q, irq_d;

    logic                   in_push, in_pop, res_push, res_pop;
    logic signed [ACCW-1:0] res_push_data;

    logic                   in_win, req, wr_req, rd_req, busy;
    logic                   ctrl_wr, soft_clr, start_req;
    logic                   in_full, in_empty, res_empty, res_room;
    logic [4:0]             off;
    logic                   unused_ok;

    // Bus decode: a request is accepted only when no ack is in flight.
    assign in_win    = (wb_adr_i[31:5] == BASE_ADDRESS[31:5]);
    assign req       = wb_cyc_i & wb_stb_i & in_win & ~ack_q;
    assign wr_req    = req & wb_we_i;
    assign rd_req    = req & ~wb_we_i;
    assign off       = wb_adr_i[4:0];
    assign busy      = (state_q != S_IDLE);
    assign ctrl_wr   = wr_req && (off == OFF_CTRL);
    assign soft_clr  = ctrl_wr & wb_dat_i[1];
    assign start_req = ctrl_wr & wb_dat_i[0] & ~wb_dat_i[1];
    assign in_full   = (in_cnt_q == ICW'(IDEPTH));
    assign in_empty  = (in_cnt_q == '0);
    assign res_empty = (res_cnt_q == '0);
    assign res_room  = (res_cnt_q <= RCW'(RDEPTH - N));
    assign unused_ok = ^{wb_sel_i, wb_dat_i};

    always_comb begin
        for (int j = 0; j < N; j++) begin
            prod[j] = PW'(x_q[k_q]) * PW'(w_q[k_q][j]);
        end
    end

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        nvec_d        = nvec_q;
        vec_cnt_d     = vec_cnt_q;
        done_d        = done_q;
        irq_en_d      = irq_en_q;
        in_ovf_d      = in_ovf_q;
        res_udf_d     = res_udf_q;
        w_err_d       = w_err_q;
        wrow_d        = wrow_q;
        wcol_d        = wcol_q;
        w_d           = w_q;
        x_d           = x_q;
        acc_d         = acc_q;
        in_push       = 1'b0;
        in_pop        = 1'b0;
        res_push      = 1'b0;
        res_pop       = 1'b0;
        res_push_data = '0;
        ack_d         = req;
        dat_d         = '0;

        if (ctrl_wr) begin
            irq_en_d = wb_dat_i[2];
            if (wb_dat_i[3]) begin
                done_d = 1'b0;
            end
        end

        // Weights are frozen while the array is running.
        if (wr_req && (off == OFF_WEIGHT)) begin
            if (busy) begin
                w_err_d = 1'b1;
            end else begin
                w_d[wrow_q][wcol_q] = wb_dat_i[DW-1:0];
                if (wcol_q == KW'(N - 1)) begin
                    wcol_d = '0;
                    wrow_d = (wrow_q == KW'(N - 1)) ? '0 : wrow_q + KW'(1);
                end else begin
                    wcol_d = wcol_q + KW'(1);
                end
            end
        end

        if (wr_req && (off == OFF_INPUT)) begin
            if (in_full) begin
                in_ovf_d = 1'b1;
            end else begin
                in_push = 1'b1;
            end
        end

        if (rd_req) begin
            case (off)
                OFF_STATUS: dat_d = {16'h0000, 8'(res_cnt_q), w_err_q, res_udf_q, in_ovf_q,
                                     res_empty, in_full, in_empty, done_q, busy};
                OFF_RESULT: begin
                    if (res_empty) begin
                        res_udf_d = 1'b1;
                    end else begin
                        res_pop = 1'b1;
                        dat_d   = 32'(res_mem_q[res_rd_q]);
                    end
                end
                default: dat_d = '0;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    if (wb_dat_i[15:8] == 8'd0) begin
                        done_d = 1'b1;
                    end else begin
                        done_d    = 1'b0;
                        nvec_d    = wb_dat_i[15:8];
                        vec_cnt_d = '0;
                        state_d   = S_WAIT;
                    end
                end
            end
            // Only start a vector when all N of its results are guaranteed a slot.
            S_WAIT: begin
                if (!in_empty && res_room) begin
                    in_pop = 1'b1;
                    for (int i = 0; i < N; i++) begin
                        x_d[i]   = in_mem_q[in_rd_q][i*DW +: DW];
                        acc_d[i] = '0;
                    end
                    k_d     = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                for (int j = 0; j < N; j++) begin
                    acc_d[j] = acc_q[j] + ACCW'(prod[j]);
                end
                if (k_q == KW'(N - 1)) begin
                    k_d     = '0;
                    state_d = S_PUSH;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_PUSH: begin
                res_push      = 1'b1;
                res_push_data = acc_q[k_q];
                if (k_q == KW'(N - 1)) begin
                    k_d       = '0;
                    vec_cnt_d = vec_cnt_q + 8'd1;
                    if ((vec_cnt_q + 8'd1) == nvec_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_wr_d   = in_wr_q + IAW'(in_push);
        in_rd_d   = in_rd_q + IAW'(in_pop);
        in_cnt_d  = in_cnt_q + ICW'(in_push) - ICW'(in_pop);
        res_wr_d  = res_wr_q + RAW'(res_push);
        res_rd_d  = res_rd_q + RAW'(res_pop);
        res_cnt_d = res_cnt_q + RCW'(res_push) - RCW'(res_pop);

        // Soft clear overrides everything except the weight contents.
        if (soft_clr) begin
            state_d   = S_IDLE;
            k_d       = '0;
            done_d    = 1'b0;
            in_ovf_d  = 1'b0;
            res_udf_d = 1'b0;
            w_err_d   = 1'b0;
            wrow_d    = '0;
            wcol_d    = '0;
            res_push  = 1'b0;
            in_wr_d   = '0;
            in_rd_d   = '0;
            in_cnt_d  = '0;
            res_wr_d  = '0;
            res_rd_d  = '0;
            res_cnt_d = '0;
        end

        irq_d = done_d & irq_en_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            nvec_q    <= '0;
            vec_cnt_q <= '0;
            done_q    <= 1'b0;
            irq_en_q  <= 1'b0;
            in_ovf_q  <= 1'b0;
            res_udf_q <= 1'b0;
            w_err_q   <= 1'b0;
            wrow_q    <= '0;
            wcol_q    <= '0;
            for (int i = 0; i < N; i++) begin
                x_q[i]   <= '0;
                acc_q[i] <= '0;
                for (int j = 0; j < N; j++) begin
                    w_q[i][j] <= '0;
                end
            end
            in_wr_q   <= '0;
            in_rd_q   <= '0;
            in_cnt_q  <= '0;
            res_wr_q  <= '0;
            res_rd_q  <= '0;
            res_cnt_q <= '0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            nvec_q    <= nvec_d;
            vec_cnt_q <= vec_cnt_d;
            done_q    <= done_d;
            irq_en_q  <= irq_en_d;
            in_ovf_q  <= in_ovf_d;
            res_udf_q <= res_udf_d;
            w_err_q   <= w_err_d;
            wrow_q    <= wrow_d;
            wcol_q    <= wcol_d;
            w_q       <= w_d;
            x_q       <= x_d;
            acc_q     <= acc_d;
            in_wr_q   <= in_wr_d;
            in_rd_q   <= in_rd_d;
            in_cnt_q  <= in_cnt_d;
            res_wr_q  <= res_wr_d;
            res_rd_q  <= res_rd_d;
            res_cnt_q <= res_cnt_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            irq_q     <= irq_d;
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (in_push) begin
            in_mem_q[in_wr_q] <= wb_dat_i[VW-1:0];
        end
        if (res_push) begin
            res_mem_q[res_wr_q] <= res_push_data;
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign irq_o    = irq_q;

endmodule
